// File: rtl/irq_encoder_32x5_pkg.sv
// irq_encoder_32x5_pkg: shared widths and FSM state encoding for the round-robin request encoder
package irq_encoder_32x5_pkg;
  localparam int W = 5;
  localparam int N = 1 << W;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/irq_encoder_32x5_rr_priority_enc.sv
// rr_priority_enc_32x5: combinational round-robin pick; pending/ptr in, first set bit at or above ptr (wrapping) as idx, any = pending nonzero
module rr_priority_enc_32x5
  import irq_encoder_32x5_pkg::*;
(
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [W-1:0] off;
  assign dbl = {pending, pending} >> ptr;
  assign rot = dbl[N-1:0];
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? W'(i) : off;
  end
  assign idx = off + ptr;
  assign any = |pending;
endmodule

// File: rtl/irq_encoder_32x5.sv
// irq_encoder_32x5: sticky 32-line request latch with round-robin VALID/ACK index handoff; CLK/RST in, REQ/ACK in, IDX/VALID/PENDING/DROP registered out
module irq_encoder_32x5
  import irq_encoder_32x5_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  input  logic         ACK,
  output logic [W-1:0] IDX,
  output logic         VALID,
  output logic [N-1:0] PENDING,
  output logic         DROP
);
  state_t state, state_nx;
  logic [W-1:0] ptr, ptr_nx, idx_nx, sel;
  logic any;
  logic [N-1:0] clr;
  rr_priority_enc_32x5 u_enc (.pending(PENDING), .ptr(ptr), .idx(sel), .any(any));
  assign clr = (state == GRANT && ACK) ? N'(1) << IDX : '0;
  assign VALID = (state == GRANT);
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = (state == IDLE) ? (any ? GRANT : IDLE) : (ACK ? IDLE : GRANT);
  always_comb begin
    idx_nx = (state == IDLE && any) ? sel : IDX;
    ptr_nx = (state == GRANT && ACK) ? IDX + W'(1) : ptr;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      IDX <= '0;
      ptr <= '0;
      PENDING <= '0;
      DROP <= 1'b0;
    end else begin
      IDX <= idx_nx;
      ptr <= ptr_nx;
      PENDING <= (PENDING & ~clr) | REQ;
      DROP <= |(REQ & PENDING & ~clr);
    end
endmodule

// File: tb/tb_irq_encoder_32x5.sv
// tb_irq_encoder_32x5: scoreboard bench for the round-robin request encoder
module tb_irq_encoder_32x5;
  logic CLK = 1'b0;
  logic RST, ACK;
  logic [31:0] REQ;
  logic [4:0] IDX;
  logic VALID, DROP;
  logic [31:0] PENDING;
  int compared = 0;
  int mismatched = 0;
  int q[$];
  int exp_idx;
  irq_encoder_32x5 dut (.CLK(CLK), .RST(RST), .REQ(REQ), .ACK(ACK), .IDX(IDX), .VALID(VALID), .PENDING(PENDING), .DROP(DROP));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic apply_reset();
    RST = 1'b1;
    REQ = '0;
    ACK = 1'b0;
    tick();
    RST = 1'b0;
  endtask
  task automatic test_reset();
    RST = 1'b1;
    REQ = '0;
    ACK = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    compared++; if (IDX !== 5'd0) begin mismatched++; $display("FAIL reset_idx: got %0d want 0", IDX); end
    compared++; if (VALID !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", VALID); end
    compared++; if (PENDING !== 32'h0) begin mismatched++; $display("FAIL reset_pending: got %h want 0", PENDING); end
    compared++; if (DROP !== 1'b0) begin mismatched++; $display("FAIL reset_drop: got %0b want 0", DROP); end
    REQ = 32'h0000_0080;
    tick();
    REQ = '0;
    q.push_back(7);
    tick();
    exp_idx = q.pop_front();
    compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL pre_reset_grant: got valid=%0b idx=%0d want 1/%0d", VALID, IDX, exp_idx); end
    #2 RST = 1'b1;
    #1;
    compared++; if (IDX !== 5'd0 || VALID !== 1'b0 || PENDING !== 32'h0) begin mismatched++; $display("FAIL async_reset: got idx=%0d valid=%0b pending=%h want 0/0/0", IDX, VALID, PENDING); end
    tick();
    RST = 1'b0;
  endtask
  task automatic test_single();
    apply_reset();
    REQ = 32'h0000_0100;
    tick();
    REQ = '0;
    compared++; if (PENDING !== 32'h0000_0100 || VALID !== 1'b0) begin mismatched++; $display("FAIL single_pending: got pending=%h valid=%0b want 00000100/0", PENDING, VALID); end
    q.push_back(8);
    tick();
    exp_idx = q.pop_front();
    compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL single_grant: got valid=%0b idx=%0d want 1/%0d", VALID, IDX, exp_idx); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    compared++; if (VALID !== 1'b0 || PENDING !== 32'h0) begin mismatched++; $display("FAIL single_ack: got valid=%0b pending=%h want 0/0", VALID, PENDING); end
  endtask
  task automatic test_round_robin();
    apply_reset();
    REQ = 32'h8000_0003;
    tick();
    REQ = '0;
    q.push_back(0);
    q.push_back(1);
    q.push_back(31);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_idx = q.pop_front();
      compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL rr_grant%0d: got valid=%0b idx=%0d want 1/%0d", k, VALID, IDX, exp_idx); end
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      compared++; if (VALID !== 1'b0) begin mismatched++; $display("FAIL rr_idle%0d: got valid=%0b want 0", k, VALID); end
    end
    compared++; if (PENDING !== 32'h0) begin mismatched++; $display("FAIL rr_drained: got %h want 0", PENDING); end
  endtask
  task automatic test_wrap();
    apply_reset();
    REQ = 32'h8000_0000;
    tick();
    REQ = '0;
    q.push_back(31);
    tick();
    exp_idx = q.pop_front();
    compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL wrap_31: got valid=%0b idx=%0d want 1/%0d", VALID, IDX, exp_idx); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    REQ = 32'h4000_0001;
    tick();
    REQ = '0;
    q.push_back(0);
    q.push_back(30);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_idx = q.pop_front();
      compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL wrap_grant%0d: got valid=%0b idx=%0d want 1/%0d", k, VALID, IDX, exp_idx); end
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
    end
    REQ = 32'h0000_0001;
    tick();
    REQ = '0;
    q.push_back(0);
    tick();
    exp_idx = q.pop_front();
    compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL wrap_ptr31: got valid=%0b idx=%0d want 1/%0d", VALID, IDX, exp_idx); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask
  task automatic test_collision();
    apply_reset();
    REQ = 32'h0000_0220;
    tick();
    REQ = '0;
    q.push_back(5);
    tick();
    exp_idx = q.pop_front();
    compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL coll_first: got valid=%0b idx=%0d want 1/%0d", VALID, IDX, exp_idx); end
    ACK = 1'b1;
    REQ = 32'h0000_0020;
    tick();
    ACK = 1'b0;
    REQ = '0;
    compared++; if (PENDING !== 32'h0000_0220 || DROP !== 1'b0) begin mismatched++; $display("FAIL coll_setwins: got pending=%h drop=%0b want 00000220/0", PENDING, DROP); end
    q.push_back(9);
    q.push_back(5);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_idx = q.pop_front();
      compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL coll_grant%0d: got valid=%0b idx=%0d want 1/%0d", k, VALID, IDX, exp_idx); end
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
    end
    compared++; if (PENDING !== 32'h0) begin mismatched++; $display("FAIL coll_drained: got %h want 0", PENDING); end
  endtask
  task automatic test_drop();
    apply_reset();
    REQ = 32'h0000_0008;
    tick();
    tick();
    REQ = '0;
    compared++; if (DROP !== 1'b1 || PENDING !== 32'h0000_0008) begin mismatched++; $display("FAIL drop_pulse: got drop=%0b pending=%h want 1/00000008", DROP, PENDING); end
    tick();
    compared++; if (DROP !== 1'b0 || PENDING !== 32'h0000_0008) begin mismatched++; $display("FAIL drop_clear: got drop=%0b pending=%h want 0/00000008", DROP, PENDING); end
    compared++; if (VALID !== 1'b1 || IDX !== 5'd3) begin mismatched++; $display("FAIL drop_grant: got valid=%0b idx=%0d want 1/3", VALID, IDX); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    compared++; if (PENDING !== 32'h0 || DROP !== 1'b0) begin mismatched++; $display("FAIL drop_ack: got pending=%h drop=%0b want 0/0", PENDING, DROP); end
  endtask
  task automatic test_ack_idle();
    apply_reset();
    ACK = 1'b1;
    REQ = 32'h0000_0010;
    tick();
    REQ = '0;
    compared++; if (PENDING !== 32'h0000_0010 || VALID !== 1'b0) begin mismatched++; $display("FAIL ackidle_pending: got pending=%h valid=%0b want 00000010/0", PENDING, VALID); end
    tick();
    ACK = 1'b0;
    compared++; if (PENDING !== 32'h0000_0010 || VALID !== 1'b1 || IDX !== 5'd4) begin mismatched++; $display("FAIL ackidle_grant: got pending=%h valid=%0b idx=%0d want 00000010/1/4", PENDING, VALID, IDX); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask
  task automatic test_back_to_back();
    apply_reset();
    REQ = 32'h0000_0044;
    tick();
    q.push_back(2);
    q.push_back(6);
    q.push_back(2);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_idx = q.pop_front();
      compared++; if (VALID !== 1'b1 || IDX !== exp_idx[4:0]) begin mismatched++; $display("FAIL level_grant%0d: got valid=%0b idx=%0d want 1/%0d", k, VALID, IDX, exp_idx); end
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      compared++; if (VALID !== 1'b0 || PENDING !== 32'h0000_0044) begin mismatched++; $display("FAIL level_idle%0d: got valid=%0b pending=%h want 0/00000044", k, VALID, PENDING); end
    end
    REQ = '0;
  endtask
  initial begin
    RST = 1'b1;
    REQ = '0;
    ACK = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_collision();
    test_drop();
    test_ack_idle();
    test_back_to_back();
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL scoreboard_empty: got %0d left want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/irq_encoder_32x5.md
Name: irq_encoder_32x5

Overview:
Sequential 32-to-5 request encoder, the counterpart of the 5x32 decoder. It accepts 32 request lines, latches them into a sticky pending vector, and presents one pending request at a time as a 5-bit index. Selection is round-robin, and each index is handed off with a VALID/ACK handshake. It serves as the interrupt/exception source encoder that feeds the control unit.

Parameters:
N, 32, number of request lines; must equal 2**W.
W, 5, index width.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
REQ  input  N  request pulses or levels; bit i set means source i requests.
ACK  input  1  consumer accepts the presented index; meaningful only while VALID=1.
IDX  output W  index of the granted request; registered.
VALID  output 1  IDX holds a granted, not-yet-acknowledged request; registered.
PENDING  output N  current sticky pending vector; registered.
DROP  output 1  one-cycle pulse; a REQ bit arrived while that bit was already pending.

Behaviour:
- Reset (asynchronous, any time, including mid-grant): PENDING=0, IDX=0, VALID=0, DROP=0, internal rotate pointer ptr=0, state=IDLE. The first edge after RST deasserts behaves as a normal edge.
- Pending update on every edge: PENDING <= (PENDING & ~clr) | REQ.
  - clr is onehot(IDX) when VALID&ACK, otherwise 0.
  - If REQ[i] and clr[i] occur in the same cycle, set wins: bit i stays pending as a new event.
- DROP <= |(REQ & PENDING & ~clr). An acked bit re-requested in the same cycle is not a drop.
- Selection (combinational): the first set bit of PENDING scanning upward from ptr, wrapping from N-1 to 0. Example: ptr=31 with only bit 0 pending selects 0.
- FSM, two states:
  - IDLE: VALID=0. If PENDING!=0 at the edge, IDX <= selection, VALID <= 1, go to GRANT. Otherwise stay.
  - GRANT: VALID=1. IDX is held stable regardless of REQ changes. On ACK: VALID <= 0, ptr <= (IDX+1) mod N (5-bit natural wrap), go to IDLE. Without ACK, stay.
- Latency: REQ sampled at edge k sets PENDING after edge k; VALID=1 after edge k+1.
- After ACK there is always exactly one IDLE cycle (VALID=0) before the next grant, so maximum throughput is one grant per 2 cycles.
- Fairness: a source cannot be granted twice while another pending source is skipped. This follows from the ptr advance.
- ACK while VALID=0 is ignored and has no effect on PENDING or ptr.
- REQ held high as a level re-sets its bit the cycle after ACK clears it. Such a source is re-served only after the rotation returns to it.

Decomposition:
- N and W, plus state encodings IDLE=1'b0 and GRANT=1'b1, go as `define constants in prj_definition.v.
- One sub-module: rr_priority_enc_32x5. It is combinational: it takes the pending vector and ptr and returns the selected index and an any-set flag. Implementation: rotate right by ptr, lowest-set-bit priority encode, add ptr mod 32.
- Do not use a 32-way case statement.
- The FSM, pending register and DROP logic live in irq_encoder_32x5.

Test Plan:
- Reset: RST=1 mid-GRANT with IDX=7 → IDX=0, VALID=0, PENDING=0 immediately, before the next CLK edge.
- Single request: REQ=32'h0000_0100 for one cycle → PENDING[8]=1 after edge 1, VALID=1 and IDX=8 after edge 2. ACK=1 → VALID=0 and PENDING=0 after the edge.
- Round-robin: PENDING=32'h8000_0003, ptr=0. Grants in order 0, 1, 31, each followed by one VALID=0 cycle.
- Wrap-around: serve bit 31 (ptr becomes 0), then REQ bits 0 and 30 together → IDX=0 first, then 30.
- Collision: ACK for IDX=5 in the same cycle as REQ[5]=1 → PENDING[5] stays 1, DROP=0, and bit 5 is granted again once the rotation returns to it.
- Drop: REQ[3] asserted while PENDING[3]=1 and 3 is not being acked → DROP=1 for exactly one cycle, PENDING unchanged.
